// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
// Bundles the host load handshake and the datapath instruction/result bus of
// the instruction sequencer into one interface.
//
// Signals:
//   ld_valid   host offers one instruction (fields below)
//   ld_ready   sequencer accepts the offered instruction
//   ld_opcode  opcode field        (3 bits)
//   ld_func    ALU function field  (4 bits)
//   ld_reg1    source register 1   (3 bits)
//   ld_reg2    source register 2   (3 bits)
//   ld_regw    destination register(3 bits)
//   inst_out   instruction word to the datapath (16 bits)
//   inst_valid inst_out carries a program word this cycle
//   res_in     datapath 8-bit result
//   zero_in    datapath zero flag
//
// Modports:
//   master  the sequencer side (drives ld_ready, inst_out, inst_valid)
//   slave   the host/datapath side
// ---------------------------------------------------------------------------
interface instr_sequencer_if;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  ld_opcode;
   logic [3:0]  ld_func;
   logic [2:0]  ld_reg1;
   logic [2:0]  ld_reg2;
   logic [2:0]  ld_regw;
   logic [15:0] inst_out;
   logic        inst_valid;
   logic [7:0]  res_in;
   logic        zero_in;

   // The sequencer consumes the load fields and datapath results and
   // produces the ready and instruction stream.
   modport master (
      input  ld_valid, ld_opcode, ld_func, ld_reg1, ld_reg2, ld_regw,
      input  res_in, zero_in,
      output ld_ready, inst_out, inst_valid
   );

   // The host/datapath view is the mirror image of the sequencer view.
   modport slave (
      output ld_valid, ld_opcode, ld_func, ld_reg1, ld_reg2, ld_regw,
      output res_in, zero_in,
      input  ld_ready, inst_out, inst_valid
   );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Instruction-issue master for the 16-bit ALU/register-file datapath. Packs
// host-supplied fields into instruction words, stores them in a program
// buffer, replays them one per cycle on inst_out and captures the datapath
// result and zero flag for every issued word.
//
// Word format: [15:13]=regw [12:10]=reg1 [9:7]=reg2 [6:3]=func [2:0]=opcode
//
// Parameters:
//   DEPTH  program buffer entries (power of two, 2..64)
//   AW     pointer width, $clog2(DEPTH)
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   bus          instr_sequencer_if.master (load handshake, inst/result bus)
//   clear        empty the program (IDLE only)
//   start        begin a run (IDLE only, needs a non-empty program)
//   abort        terminate a run
//   stall        suppress issue this cycle
//   loop_mode    repeat the program (only with SEQ_LOOP_EN)
//   busy         state is RUN or DRAIN
//   done         one-cycle pulse on run completion
//   pc           index of the next word to issue
//   prog_len     number of stored words
//   last_result  most recently captured res_in
//   zero_count   zero_in=1 captures this run, saturating
//
// Build option:
//   SEQ_LOOP_EN  when defined, loop_mode=1 wraps the run back to word 0 at
//                the last issue instead of draining; abort is the only exit.
// ---------------------------------------------------------------------------
module instr_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instr_sequencer_if.master    bus,
   input  logic                 clear,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 stall,
   input  logic                 loop_mode,
   output logic                 busy,
   output logic                 done,
   output logic [AW-1:0]        pc,
   output logic [AW:0]          prog_len,
   output logic [7:0]           last_result,
   output logic [AW:0]          zero_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW:0]   prog_len_q, prog_len_d;
   logic [15:0]   inst_out_q, inst_out_d;
   logic          inst_valid_q, inst_valid_d;
   logic          ld_ready_q, ld_ready_d;
   logic [7:0]    last_result_q, last_result_d;
   logic [AW:0]   zero_count_q, zero_count_d;

   logic [15:0]   mem_q [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [15:0]   mem_wdata;

   logic          last_word;
   logic          loop_wrap;

   // Looping is only honoured when the build enables it; otherwise the
   // input is tied off so every run drains after prog_len issues.
`ifdef SEQ_LOOP_EN
   assign loop_wrap = loop_mode;
`else
   logic unused_loop_mode;
   assign unused_loop_mode = loop_mode;
   assign loop_wrap        = 1'b0;
`endif

   // Next-state and datapath decisions. The result capture is independent
   // of the state so that a word already on inst_out when an abort lands
   // still has its result recorded.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      prog_len_d    = prog_len_q;
      inst_out_d    = 16'h0000;
      inst_valid_d  = 1'b0;
      last_result_d = last_result_q;
      zero_count_d  = zero_count_q;
      mem_we        = 1'b0;
      mem_waddr     = prog_len_q[AW-1:0];
      mem_wdata     = {bus.ld_regw, bus.ld_reg1, bus.ld_reg2, bus.ld_func, bus.ld_opcode};
      last_word     = ({1'b0, pc_q} == (prog_len_q - 1'b1));

      if (inst_valid_q) begin
         last_result_d = bus.res_in;
         if (bus.zero_in && (zero_count_q != '1)) begin
            zero_count_d = zero_count_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            // clear overrides both a load and a start in the same cycle
            if (clear) begin
               prog_len_d = '0;
            end else begin
               if (bus.ld_valid && ld_ready_q) begin
                  mem_we     = 1'b1;
                  prog_len_d = prog_len_q + 1'b1;
               end
               if (start && (prog_len_q != '0)) begin
                  state_d      = RUN;
                  pc_d         = '0;
                  zero_count_d = '0;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (!stall) begin
               inst_out_d   = mem_q[pc_q];
               inst_valid_d = 1'b1;
               // pc parks on the last word when the run drains
               if (last_word) begin
                  if (loop_wrap) begin
                     pc_d = '0;
                  end else begin
                     state_d = DRAIN;
                  end
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            // The final word is on inst_out in this cycle, so its result is
            // captured at this edge and the run can complete.
            state_d = abort ? IDLE : DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // ld_ready is registered from the next state so it reads 0 in reset
      ld_ready_d = (state_d == IDLE) && (prog_len_d != FULL_LEN);
   end

   // Control and output registers; all return to zero/IDLE on reset, which
   // also discards the program by zeroing prog_len.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         prog_len_q    <= '0;
         inst_out_q    <= 16'h0000;
         inst_valid_q  <= 1'b0;
         ld_ready_q    <= 1'b0;
         last_result_q <= 8'h00;
         zero_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         prog_len_q    <= prog_len_d;
         inst_out_q    <= inst_out_d;
         inst_valid_q  <= inst_valid_d;
         ld_ready_q    <= ld_ready_d;
         last_result_q <= last_result_d;
         zero_count_q  <= zero_count_d;
      end
   end

   // Program buffer storage; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.inst_out   = inst_out_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.ld_ready   = ld_ready_q;
   assign busy           = (state_q == RUN) || (state_q == DRAIN);
   assign done           = (state_q == DONE);
   assign pc             = pc_q;
   assign prog_len       = prog_len_q;
   assign last_result    = last_result_q;
   assign zero_count     = zero_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench for instr_sequencer. Words expected on inst_out are
// queued when a run is launched; a monitor on the falling edge pops and
// compares every valid word and checks inst_out is zero otherwise. Status
// outputs are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          stall = 1'b0;
   logic          loop_mode = 1'b0;
   logic          busy;
   logic          done;
   logic [AW-1:0] pc;
   logic [AW:0]   prog_len;
   logic [7:0]    last_result;
   logic [AW:0]   zero_count;
   logic          force_zero = 1'b0;

   int            checks = 0;
   int            errors = 0;
   int            done_seen = 0;
   int            valid_seen = 0;
   logic [15:0]   exp_q [$];
   logic [15:0]   prog_words [$];
   logic [15:0]   mon_word;

   instr_sequencer_if bus ();

   instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .clear      (clear),
      .start      (start),
      .abort      (abort),
      .stall      (stall),
      .loop_mode  (loop_mode),
      .busy       (busy),
      .done       (done),
      .pc         (pc),
      .prog_len   (prog_len),
      .last_result(last_result),
      .zero_count (zero_count)
   );

   // Clock with a 10-unit period.
   always #5 clk = ~clk;

   // Simple datapath model: result is the sum of the word's two bytes, or a
   // forced zero result when the zero-flag scenario is being exercised.
   assign bus.res_in  = force_zero ? 8'h00 : (bus.inst_out[15:8] + bus.inst_out[7:0]);
   assign bus.zero_in = force_zero ? 1'b1 : (bus.res_in == 8'h00);

   function automatic logic [7:0] result_of(input logic [15:0] w);
      return w[15:8] + w[7:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: every valid word must match the head of the expected queue,
   // and an idle bus must carry the all-zero no-op word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_seen++;
         if (bus.inst_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_issue: got %h expected none", bus.inst_out);
            end else begin
               mon_word = exp_q.pop_front();
               checkOutput("inst_out", 32'(bus.inst_out), 32'(mon_word));
            end
         end else begin
            checkOutput("idle_inst_out", 32'(bus.inst_out), 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction for one cycle and remember the packed word.
   task automatic applyStimulus(input logic [2:0] op, input logic [3:0] fn,
                                input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] rw);
      bus.ld_opcode = op;
      bus.ld_func   = fn;
      bus.ld_reg1   = r1;
      bus.ld_reg2   = r2;
      bus.ld_regw   = rw;
      bus.ld_valid  = 1'b1;
      tick();
      bus.ld_valid  = 1'b0;
      prog_words.push_back({rw, r1, r2, fn, op});
   endtask

   task automatic clear_prog();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      prog_words.delete();
   endtask

   task automatic expect_program();
      foreach (prog_words[i]) exp_q.push_back(prog_words[i]);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((done !== 1'b1) && (n < budget));
      checkOutput(name, 32'(done), 32'h1);
      tick();
   endtask

   initial begin
      int d0;
      int v0;
      bus.ld_valid  = 1'b0;
      bus.ld_opcode = '0;
      bus.ld_func   = '0;
      bus.ld_reg1   = '0;
      bus.ld_reg2   = '0;
      bus.ld_regw   = '0;

      // Reset state
      #12;
      checkOutput("rst_inst_out", 32'(bus.inst_out), 32'h0);
      checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
      checkOutput("rst_ld_ready", 32'(bus.ld_ready), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_done", 32'(done), 32'h0);
      checkOutput("rst_prog_len", 32'(prog_len), 32'h0);
      checkOutput("rst_zero_count", 32'(zero_count), 32'h0);
      rst_n = 1'b1;
      tick();
      checkOutput("ld_ready_after_rst", 32'(bus.ld_ready), 32'h1);

      // Single word: 16'h8533, done three cycles after start
      applyStimulus(3'd3, 4'd6, 3'd1, 3'd2, 3'd4);
      checkOutput("t1_prog_len", 32'(prog_len), 32'h1);
      checkOutput("t1_packed", 32'(prog_words[0]), 32'h8533);
      exp_q.push_back(16'h8533);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("t1_busy", 32'(busy), 32'h1);
      checkOutput("t1_done_c1", 32'(done), 32'h0);
      tick();
      checkOutput("t1_valid_c2", 32'(bus.inst_valid), 32'h1);
      checkOutput("t1_done_c2", 32'(done), 32'h0);
      tick();
      checkOutput("t1_done_c3", 32'(done), 32'h1);
      tick();
      checkOutput("t1_done_c4", 32'(done), 32'h0);
      checkOutput("t1_busy_end", 32'(busy), 32'h0);
      checkOutput("t1_last_result", 32'(last_result), 32'hB8);
      checkOutput("t1_zero_count", 32'(zero_count), 32'h0);

      // Full buffer: 16 words accepted, 17th refused
      clear_prog();
      checkOutput("t2_cleared", 32'(prog_len), 32'h0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(3'(i), 4'(15 - i), 3'(i + 1), 3'(i + 3), 3'(7 - i));
      end
      checkOutput("t2_prog_len_full", 32'(prog_len), 32'd16);
      checkOutput("t2_ld_ready_full", 32'(bus.ld_ready), 32'h0);
      bus.ld_valid = 1'b1;
      bus.ld_opcode = 3'd7;
      tick();
      bus.ld_valid = 1'b0;
      checkOutput("t2_prog_len_17th", 32'(prog_len), 32'd16);
      expect_program();
      v0 = valid_seen;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checkOutput("t2_pc", 32'(pc), 32'(i));
         tick();
      end
      wait_done("t2_done", 10);
      checkOutput("t2_issued", 32'(valid_seen - v0), 32'd16);
      checkOutput("t2_pc_end", 32'(pc), 32'd15);

      // Stall for two cycles during the second issue of a 3-word run
      clear_prog();
      applyStimulus(3'd1, 4'd2, 3'd3, 3'd4, 3'd5);
      applyStimulus(3'd3, 4'd9, 3'd0, 3'd7, 3'd2);
      applyStimulus(3'd5, 4'd1, 3'd6, 3'd1, 3'd7);
      expect_program();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      stall = 1'b1;
      tick();
      checkOutput("t3_stall_gap1", 32'(bus.inst_valid), 32'h0);
      tick();
      stall = 1'b0;
      checkOutput("t3_stall_gap2", 32'(bus.inst_valid), 32'h0);
      wait_done("t3_done", 10);

      // Zero flag on every capture of a 4-word run
      clear_prog();
      for (int i = 0; i < 4; i++) applyStimulus(3'(i), 4'(i), 3'(i), 3'(i), 3'(i));
      expect_program();
      force_zero = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t4_done", 12);
      force_zero = 1'b0;
      checkOutput("t4_zero_count", 32'(zero_count), 32'd4);
      checkOutput("t4_last_result", 32'(last_result), 32'h0);

      // clear wins over simultaneous load and start
      clear = 1'b1;
      start = 1'b1;
      bus.ld_valid = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      bus.ld_valid = 1'b0;
      prog_words.delete();
      checkOutput("t5_clear_len", 32'(prog_len), 32'h0);
      checkOutput("t5_clear_busy", 32'(busy), 32'h0);

      // start with an empty program is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("t5_empty_start", 32'(busy), 32'h0);

      // abort one cycle after start on a 5-word run, then replay
      for (int i = 0; i < 5; i++) applyStimulus(3'(i + 2), 4'(i * 3), 3'(i), 3'(4 - i), 3'(i + 1));
      d0 = done_seen;
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("t6_abort_busy", 32'(busy), 32'h0);
      checkOutput("t6_abort_valid", 32'(bus.inst_valid), 32'h0);
      checkOutput("t6_abort_inst", 32'(bus.inst_out), 32'h0);
      tick();
      tick();
      checkOutput("t6_no_done", 32'(done_seen - d0), 32'h0);
      expect_program();
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("t6_restart_pc", 32'(pc), 32'h0);
      wait_done("t6_replay_done", 12);

      // abort with a word in flight: its result is still captured, pc held
      exp_q.push_back(prog_words[0]);
      exp_q.push_back(prog_words[1]);
      d0 = done_seen;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("t7_pc_held", 32'(pc), 32'd2);
      checkOutput("t7_busy", 32'(busy), 32'h0);
      checkOutput("t7_capture", 32'(last_result), 32'(result_of(prog_words[1])));
      tick();
      checkOutput("t7_no_done", 32'(done_seen - d0), 32'h0);

`ifdef SEQ_LOOP_EN
      // Looping two words until abort, with no done pulse
      clear_prog();
      applyStimulus(3'd3, 4'd6, 3'd1, 3'd2, 3'd4);
      applyStimulus(3'd1, 4'd5, 3'd2, 3'd3, 3'd6);
      for (int i = 0; i < 3; i++) expect_program();
      d0 = done_seen;
      loop_mode = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      checkOutput("t8_loop_busy", 32'(busy), 32'h1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      loop_mode = 1'b0;
      checkOutput("t8_abort_busy", 32'(busy), 32'h0);
      tick();
      checkOutput("t8_no_done", 32'(done_seen - d0), 32'h0);
`endif

      tick();
      checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
